// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: CPU-side initiator for the fixed-latency memory.
// Ports: clk/rst, req_* handshake, resp_* pulse, stall, mem_* pins; MEMCTRL_PERF_EN adds perf_*.
module mem_req_ctrl #(
  parameter int ASIZE   = 16,
  parameter int DSIZE   = 16,
  parameter int LATENCY = 3,
  parameter int CNTW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [ASIZE-1:0] req_addr,
  input  logic [DSIZE-1:0] req_wdata,
  output logic             req_ready,
  output logic             stall,
  output logic             resp_valid,
  output logic             resp_is_wr,
  output logic [DSIZE-1:0] resp_rdata,
  output logic             mem_cs,
  output logic             mem_wen,
  output logic [ASIZE-1:0] mem_addr,
  output logic [DSIZE-1:0] mem_wdata,
  input  logic [DSIZE-1:0] mem_rdata
`ifdef MEMCTRL_PERF_EN
  ,
  output logic [15:0]      perf_rd_cnt,
  output logic [15:0]      perf_wr_cnt,
  output logic [15:0]      perf_stall_cnt
`endif
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(LATENCY - 1);

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_is_wr_q, resp_is_wr_d;
  logic [DSIZE-1:0]  resp_rdata_q, resp_rdata_d;
  logic              accept;

  // The last wait cycle doubles as a free accept slot.
  assign req_ready = ~rst & ((state_q == S_IDLE) | (cnt_q == '0));
  assign stall     = req_valid & ~req_ready;
  assign accept    = req_valid & req_ready;

  // wen must be inactive outside the accept cycle: the memory
  // pipelines it unconditionally and would write otherwise.
  assign mem_cs    = accept;
  assign mem_wen   = ~(accept & req_we);
  assign mem_addr  = req_addr;
  assign mem_wdata = req_wdata;

  assign resp_valid = resp_valid_q;
  assign resp_is_wr = resp_is_wr_q;
  assign resp_rdata = resp_rdata_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    resp_valid_d = 1'b0;
    resp_is_wr_d = resp_is_wr_q;
    resp_rdata_d = resp_rdata_q;
    if (state_q == S_WAIT) begin
      if (cnt_q == '0) begin
        resp_valid_d = 1'b1;
        resp_is_wr_d = we_q;
        resp_rdata_d = we_q ? '0 : mem_rdata;
        state_d      = S_IDLE;
      end else begin
        cnt_d = cnt_q - CNTW'(1);
      end
    end
    if (accept) begin
      state_d = S_WAIT;
      cnt_d   = CNT_LOAD;
      we_d    = req_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_is_wr_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      resp_valid_q <= resp_valid_d;
      resp_is_wr_q <= resp_is_wr_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

`ifdef MEMCTRL_PERF_EN
  logic [15:0] perf_rd_q, perf_wr_q, perf_stall_q;

  assign perf_rd_cnt    = perf_rd_q;
  assign perf_wr_cnt    = perf_wr_q;
  assign perf_stall_cnt = perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_rd_q    <= '0;
      perf_wr_q    <= '0;
      perf_stall_q <= '0;
    end else begin
      if (accept & ~req_we & (perf_rd_q != 16'hFFFF))
        perf_rd_q <= perf_rd_q + 16'd1;
      if (accept & req_we & (perf_wr_q != 16'hFFFF))
        perf_wr_q <= perf_wr_q + 16'd1;
      if (stall & (perf_stall_q != 16'hFFFF))
        perf_stall_q <= perf_stall_q + 16'd1;
    end
  end
`endif

endmodule
